// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : loader_pkg
// Brief    : Shared types for the UART program loader: FSM state encoding
//            and the committed-word counter type.
// Revision : 1.0  initial release
// ============================================================================
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    HDR   = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6,
    CHK   = 3'd7
  } loader_state_t;

  typedef logic [15:0] word_count_t;

endpackage
`default_nettype wire

// File: rtl/word_packer.sv
`default_nettype none
// ============================================================================
// Module   : word_packer
// Brief    : Assembles received bytes into a memory word in the configured
//            byte order and flags the byte that completes the word.
// Revision : 1.0  initial release
// ============================================================================
module word_packer #(
  parameter int WORD_BYTES = 4,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              data_byte,
  input  logic                    valid,
  input  logic                    clear,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    word_ready
);

  localparam int DW = 8 * WORD_BYTES;
  localparam logic [3:0] LAST_BYTE = 4'(WORD_BYTES - 1);

  logic [3:0]    cnt;
  logic [DW-1:0] word_next;

  // Concatenate-then-truncate keeps both orders valid for a one-byte word.
  if (BIG_ENDIAN) begin : g_big
    assign word_next = DW'({word, data_byte});
  end else begin : g_little
    assign word_next = DW'({data_byte, word} >> 8);
  end

  assign word_ready = valid && (cnt == LAST_BYTE);

  // Shift register and byte-in-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (clear) begin
      word <= '0;
      cnt  <= '0;
    end else if (valid) begin
      word <= word_next;
      cnt  <= word_ready ? 4'd0 : cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : UART boot loader. On a rising edge of flash it clears program
//            memory, reads a length header (MSB first), then writes that many
//            words starting at BASE_ADDR and reports done/error.
// Options  : LOADER_CHECKSUM_EN - adds a running XOR over header and data
//            bytes and a trailer byte compared against it in state CHK.
// Revision : 1.0  initial release
// ============================================================================
module program_loader
  import loader_pkg::*;
#(
  parameter int                    WORD_BYTES = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter int                    LEN_BYTES  = 2,
  parameter bit                    BIG_ENDIAN = 1'b1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flash,
  input  logic [7:0]              uart_data,
  input  logic                    uart_valid,
  output logic                    mem_clear,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_waddr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             words_written
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int LW = 8 * LEN_BYTES;
  localparam logic [3:0] HDR_LAST = 4'(LEN_BYTES - 1);

  loader_state_t state, state_next;
  logic          flash_q;
  logic          rise, abort, set_done, set_err;
  logic [LW-1:0] len_r, len_next;
  logic [3:0]    hcnt;
  logic          hdr_last, len_zero, len_big, last_word;
  logic          pk_valid, pk_clear, word_ready;
  logic [DW-1:0] pk_word;
  logic [ADDR_WIDTH-1:0] waddr;

  assign rise      = flash && !flash_q;
  assign busy      = (state == CLEAR) || (state == HDR) || (state == DATA) ||
                     (state == WRITE) || (state == CHK);
  assign abort     = busy && !flash;
  assign mem_clear = (state == CLEAR);
  assign mem_we    = (state == WRITE);

  assign len_next  = LW'({len_r, uart_data});
  assign hdr_last  = (hcnt == HDR_LAST);
  assign len_zero  = (len_next == '0);
  assign len_big   = (64'(len_next) > 64'(MEM_DEPTH));
  assign last_word = ((32'(words_written) + 32'd1) == 32'(len_r));

  // A byte during WRITE is the next word's first byte unless this was the last word.
  assign pk_valid  = uart_valid && ((state == DATA) || ((state == WRITE) && !last_word));
  assign pk_clear  = (state == IDLE) || (state == CLEAR);

  assign waddr     = BASE_ADDR + ADDR_WIDTH'(words_written) * ADDR_WIDTH'(WORD_BYTES);
  assign mem_waddr = mem_we ? waddr : '0;
  assign mem_wdata = mem_we ? pk_word : '0;

  word_packer #(
    .WORD_BYTES (WORD_BYTES),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_byte  (uart_data),
    .valid      (pk_valid),
    .clear      (pk_clear),
    .word       (pk_word),
    .word_ready (word_ready)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       chk_ok;

  // Running XOR over every accepted header and data byte of the session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (state == CLEAR) begin
      csum <= '0;
    end else if (((state == HDR) && uart_valid) || pk_valid) begin
      csum <= csum ^ uart_data;
    end
  end

  assign chk_ok = (uart_data == csum);
`endif

  // State register; flash history resets high so a level held through reset never starts a session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      flash_q <= 1'b1;
    end else begin
      state   <= state_next;
      flash_q <= flash;
    end
  end

  // Next-state logic with completion/error events.
  always_comb begin
    state_next = state;
    set_done   = 1'b0;
    set_err    = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  if (rise) state_next = CLEAR;
        CLEAR: state_next = HDR;
        HDR: begin
          if (uart_valid && hdr_last) begin
            if (len_zero)     state_next = DONE;
            else if (len_big) state_next = ERROR;
            else              state_next = DATA;
          end
        end
        DATA:  if (word_ready) state_next = WRITE;
        WRITE: begin
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            // The trailer may already be on the line during the final write.
            if (uart_valid) state_next = chk_ok ? DONE : ERROR;
            else            state_next = CHK;
`else
            state_next = DONE;
`endif
          end else if (word_ready) begin
            state_next = WRITE;
          end else begin
            state_next = DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK:   if (uart_valid) state_next = chk_ok ? DONE : ERROR;
`endif
        DONE:  if (!flash) state_next = IDLE;
        ERROR: if (!flash) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
    set_done = (state_next == DONE) && (state != DONE);
    set_err  = abort || ((state_next == ERROR) && (state != ERROR));
  end

  // Session status: sticky flags and committed-word count, cleared on a new session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else if ((state == IDLE) && rise) begin
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      if (set_done) done  <= 1'b1;
      if (set_err)  error <= 1'b1;
      if (state == WRITE) words_written <= words_written + 16'd1;
    end
  end

  // Length header collection, MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r <= '0;
      hcnt  <= '0;
    end else if (state == CLEAR) begin
      len_r <= '0;
      hcnt  <= '0;
    end else if ((state == HDR) && uart_valid) begin
      len_r <= len_next;
      hcnt  <= hcnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Directed bench. Instance a uses default parameters; instance b
//            is little-endian, MEM_DEPTH=4, BASE_ADDR=0x100. Both share the
//            same stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n, flash, uart_valid;
  logic [7:0]  uart_data;

  logic        clr_a, we_a, busy_a, done_a, err_a;
  logic [31:0] waddr_a, wdata_a;
  logic [15:0] ww_a;
  logic        clr_b, we_b, busy_b, done_b, err_b;
  logic [31:0] waddr_b, wdata_b;
  logic [15:0] ww_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] wa_a[$], wd_a[$], wa_b[$], wd_b[$];
  int          nclr_a = 0, nclr_b = 0, both_a = 0, both_b = 0;
  logic [7:0]  stim[$];
  logic [7:0]  run_x;

  always #5 clk = ~clk;

  program_loader dut_a (
    .clk(clk), .rst_n(rst_n), .flash(flash), .uart_data(uart_data), .uart_valid(uart_valid),
    .mem_clear(clr_a), .mem_we(we_a), .mem_waddr(waddr_a), .mem_wdata(wdata_a),
    .busy(busy_a), .done(done_a), .error(err_a), .words_written(ww_a)
  );

  program_loader #(
    .BIG_ENDIAN(1'b0), .MEM_DEPTH(4), .BASE_ADDR(32'h100)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flash(flash), .uart_data(uart_data), .uart_valid(uart_valid),
    .mem_clear(clr_b), .mem_we(we_b), .mem_waddr(waddr_b), .mem_wdata(wdata_b),
    .busy(busy_b), .done(done_b), .error(err_b), .words_written(ww_b)
  );

  // Write/clear logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (we_a) begin wa_a.push_back(waddr_a); wd_a.push_back(wdata_a); end
    if (we_b) begin wa_b.push_back(waddr_b); wd_b.push_back(wdata_b); end
    if (clr_a) nclr_a++;
    if (clr_b) nclr_b++;
    if (we_a && clr_a) both_a++;
    if (we_b && clr_b) both_b++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa_a.delete(); wd_a.delete(); wa_b.delete(); wd_b.delete();
    nclr_a = 0; nclr_b = 0;
  endtask

  task automatic start_session();
    clear_log();
    run_x = 8'h00;
    flash = 1'b1;
    tick();  // IDLE -> CLEAR
    tick();  // CLEAR -> HDR
  endtask

  task automatic end_session();
    flash = 1'b0;
    tick();
    tick();
  endtask

  task automatic put(input logic [7:0] b, input bit b2b);
    run_x      = run_x ^ b;
    uart_data  = b;
    uart_valid = 1'b1;
    tick();
    if (!b2b) begin
      uart_valid = 1'b0;
      tick();
    end
  endtask

  task automatic send_stim(input bit b2b);
    foreach (stim[i]) put(stim[i], b2b);
    uart_valid = 1'b0;
  endtask

  // Checksum trailer for a complete load; nothing is sent without the option.
  task automatic send_trailer();
`ifdef LOADER_CHECKSUM_EN
    uart_data  = run_x;
    uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
`endif
    tick(); tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0; flash = 1'b1; uart_valid = 1'b0; uart_data = 8'h00; run_x = 8'h00;

    // Reset state with flash already high.
    tick(); tick();
    check("rst_busy",  busy_a, 0);
    check("rst_done",  done_a, 0);
    check("rst_error", err_a, 0);
    check("rst_ww",    ww_a, 0);
    check("rst_outs",  {clr_a, we_a, waddr_a, wdata_a}, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("hold_flash_no_session", busy_a, 0);
    check("hold_flash_no_clear",   nclr_a, 0);
    flash = 1'b0;
    tick(); tick();

    // Basic load, with the first write checked at its cycle.
    start_session();
    check("basic_clear_pulse", nclr_a, 1);
    stim = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE};
    send_stim(1'b0);
    run_x = run_x ^ 8'hEF; uart_data = 8'hEF; uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
    check("latency_we",    we_a, 1);
    check("latency_addr",  waddr_a, 32'h0);
    check("latency_data",  wdata_a, 32'hDEADBEEF);
    check("latency_clear", clr_a, 0);
    tick();
    stim = '{8'h00, 8'h00, 8'h00, 8'h13};
    send_stim(1'b0);
    send_trailer();
    check("basic_nwr",   wd_a.size(), 2);
    check("basic_d1",    wd_a[1], 32'h00000013);
    check("basic_a1",    wa_a[1], 32'h4);
    check("basic_done",  done_a, 1);
    check("basic_ww",    ww_a, 2);
    check("basic_busy",  busy_a, 0);
    check("basic_err",   err_a, 0);
    check("le_basic_d0", wd_b[0], 32'hEFBEADDE);
    check("le_basic_a0", wa_b[0], 32'h100);
    check("le_basic_d1", wd_b[1], 32'h13000000);
    check("le_basic_a1", wa_b[1], 32'h104);
    end_session();
    check("done_sticky", done_a, 1);

    // Little-endian single word.
    start_session();
    stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stim(1'b0);
    send_trailer();
    check("le_data", wd_b[0], 32'h44332211);
    check("le_addr", wa_b[0], 32'h100);
    check("le_nwr",  wd_b.size(), 1);
    check("le_done", done_b, 1);
    check("be_data", wd_a[0], 32'h11223344);
    end_session();

    // Length 5: too long for b (depth 4), fine for a.
    start_session();
    stim = '{8'h00, 8'h05};
    for (int i = 0; i < 20; i++) stim.push_back(8'(i + 1));
    send_stim(1'b0);
    send_trailer();
    check("ovf_err",    err_b, 1);
    check("ovf_no_wr",  wd_b.size(), 0);
    check("ovf_done",   done_b, 0);
    check("ovf_busy",   busy_b, 0);
    check("len5_nwr",   wd_a.size(), 5);
    check("len5_d4",    wd_a[4], 32'h11121314);
    check("len5_a4",    wa_a[4], 32'h10);
    check("len5_done",  done_a, 1);
    end_session();

    // Length zero completes at once.
    start_session();
    stim = '{8'h00, 8'h00};
    send_stim(1'b0);
    tick(); tick();
    check("len0_done", done_a, 1);
    check("len0_ww",   ww_a, 0);
    check("len0_nwr",  wd_a.size(), 0);
    end_session();

    // 1025 words exceeds default depth; following bytes are ignored.
    start_session();
    stim = '{8'h04, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stim(1'b0);
    tick();
    check("ovf1025_err",  err_a, 1);
    check("ovf1025_nwr",  wd_a.size(), 0);
    end_session();

    // Abort after six data bytes of a three-word load.
    start_session();
    stim = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_stim(1'b0);
    flash = 1'b0;
    tick();
    check("abort_busy",  busy_a, 0);
    check("abort_err",   err_a, 1);
    check("abort_done",  done_a, 0);
    tick(); tick(); tick();
    check("abort_nwr",   wd_a.size(), 1);
    check("abort_d0",    wd_a[0], 32'h01020304);
    check("abort_b_d0",  wd_b[0], 32'h04030201);
    check("abort_b_nwr", wd_b.size(), 1);

    // Back-to-back strobes: byte 5 lands in the WRITE cycle.
    start_session();
    stim = '{8'h00, 8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
    send_stim(1'b1);
    send_trailer();
    check("b2b_nwr",  wd_a.size(), 2);
    check("b2b_d0",   wd_a[0], 32'hA1A2A3A4);
    check("b2b_d1",   wd_a[1], 32'hA5A6A7A8);
    check("b2b_b_d1", wd_b[1], 32'hA8A7A6A5);
    check("b2b_done", done_a, 1);
    end_session();

    // Reset in mid-session returns to IDLE at once.
    start_session();
    stim = '{8'h00, 8'h02, 8'h55};
    send_stim(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_a, 0);
    check("midrst_ww",   ww_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(); tick();
    check("midrst_no_restart", nclr_a, 1);
    end_session();

`ifdef LOADER_CHECKSUM_EN
    // Running XOR includes the header: 00^01^01^02^03^04 = 05.
    start_session();
    stim = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_stim(1'b0);
    tick(); tick();
    check("chk_good_done", done_a, 1);
    check("chk_good_err",  err_a, 0);
    end_session();
    start_session();
    stim = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_stim(1'b0);
    tick(); tick();
    check("chk_bad_err",  err_a, 1);
    check("chk_bad_done", done_a, 0);
    end_session();
`endif

    check("we_clear_overlap_a", both_a, 0);
    check("we_clear_overlap_b", both_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
